dma_ram_arbiter: RTL and testbench
==================================

# dma_ram_arbiter

Arbitrates access to one simple dual-port block RAM (one write port, one registered read port) between the PCIe DMA engine and the custom pulse logic. The DMA engine loads pulse-width tables into the RAM. Once the DMA has been idle long enough, ownership passes to the custom logic, which then reads and writes the table. The DMA always regains the RAM immediately when it issues any access.

## Interface
Reset is synchronous and active-high on a single clock.

Parameters:
- W_ADDR, 12, RAM address width
- W_DATA, 128, RAM data width
- IDLE_CYC, 2, consecutive DMA-idle cycles before ownership is granted to custom logic (≥1)

Ports:
- clk_in  in  1  clock
- rst  in  1  synchronous active-high reset
- ram_wr_addr / ram_rd_addr  out  W_ADDR  RAM write / read address
- ram_wr_data  out  W_DATA  RAM write data
- ram_wr_en / ram_rd_en  out  1  RAM write / read enable
- ram_rd_data  in  W_DATA  RAM read data, valid 1 cycle after ram_rd_en
- dma_wr_addr / dma_rd_addr  in  W_ADDR  DMA addresses
- dma_wr_data  in  W_DATA  DMA write data
- dma_wr_en / dma_rd_en  in  1  DMA enables
- dma_rd_data  out  W_DATA  read data returned to DMA
- custom_en  out  1  custom logic owns the RAM (registered)
- custom_wr_addr / custom_rd_addr  in  W_ADDR  custom addresses
- custom_wr_data  in  W_DATA  custom write data
- custom_wr_en / custom_rd_en  in  1  custom enables
- custom_rd_data  out  W_DATA  read data returned to custom logic

## Operation
- dma_active = dma_wr_en | dma_rd_en.
- FSM states: DMA_OWN (reset state) and CUSTOM_OWN. custom_en = (state == CUSTOM_OWN).
- RAM port routing is combinational:
  - If rst is high, ram_wr_en = ram_rd_en = 0.
  - Otherwise, if dma_active or state == DMA_OWN, all ram_* outputs are driven from the dma_* inputs.
  - Otherwise, all ram_* outputs are driven from the custom_* inputs.
- Custom enables are ignored whenever they are not routed to the RAM. Such a custom request is dropped, not queued.
- Read return: rd_owner_q registers the owner of each ram_rd_en cycle (DMA or CUSTOM).
  - The next cycle, ram_rd_data goes to the matching output; the other output is 0.
  - Both outputs are 0 when no read was issued in the previous cycle.
- Addresses and data pass through unmodified. No width conversion is done.

## Timing
- Reset: state DMA_OWN, idle counter 0, custom_en 0, rd_owner_q none, so dma_rd_data = custom_rd_data = 0 one cycle after reset.
- DMA_OWN → CUSTOM_OWN: at the clock edge that ends the IDLE_CYC-th consecutive cycle with dma_active = 0. The idle counter clears whenever dma_active = 1.
- CUSTOM_OWN → DMA_OWN: at any edge where dma_active = 1.
  - The DMA access in that cycle already wins combinationally, so there is zero-cycle preemption.
  - custom_en falls at that same edge.
- Read latency: 1 cycle from the enable to the data output for both masters.
- Simultaneous DMA and custom requests while custom_en = 1: DMA wins and the custom request is dropped.
- Reset asserted mid-transfer: RAM enables are blocked immediately; the state returns to DMA_OWN at the next edge.

## Configuration
- ARB_DROP_CNT_EN: when defined, adds output drop_cnt [15:0].
  - It counts cycles where custom_en = 1 and a custom enable was dropped because dma_active = 1.
  - It saturates at 0xFFFF and is cleared by rst.
- When ARB_DROP_CNT_EN is undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package arb_pkg holds:
  - the owner enum {OWN_DMA, OWN_CUSTOM}, used for both the state and rd_owner_q;
  - default W_ADDR/W_DATA constants.
- One sub-module, arb_owner_fsm, contains the idle counter and the state register. Its input is dma_active; its outputs are state and custom_en.
- The top level contains the routing mux, the read-return steering and the optional drop counter.

## Test plan
- DMA table load: rst for 1 cycle, then DMA writes addr 0..4 with data 0x10, 0x0000_0064_012c_03e8, 0x05dc_07d0_09c4_0bb8, 0x0dac_0fa0_1194_1388, 0x157c_1770_189c_194f → ram_wr_* mirror the inputs each cycle and custom_en stays 0.
- Handover: dma_wr_en drops → custom_en rises exactly IDLE_CYC (2) edges later. Custom writes before that edge never reach ram_wr_en.
- Custom read: custom_rd_en with addr 1 → custom_rd_data = 0x0000_0064_012c_03e8 the next cycle, and dma_rd_data = 0.
- Preemption: in CUSTOM_OWN, dma_rd_en with addr 2 while custom_rd_en targets addr 3 → ram_rd_addr = 2 in the same cycle, dma_rd_data = 0x05dc_07d0_09c4_0bb8 the next cycle, custom_en = 0 after the edge, and drop_cnt = 1 (with ARB_DROP_CNT_EN).
- Mid-operation reset: rst during custom writes → ram_wr_en = 0 immediately, then custom_en = 0, state DMA_OWN and drop_cnt = 0 after the edge.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the DMA / custom-logic RAM arbiter.
//   - owner_e   : RAM owner. Used for the ownership state and for tagging
//                 which master issued the read that returns next cycle.
//   - ARB_W_*   : default RAM address / data widths.
//   - sat_inc16 : saturating 16-bit increment for the optional drop counter.
// Optional feature macro used by the top level: ARB_DROP_CNT_EN.
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam int unsigned ARB_W_ADDR = 12;
   localparam int unsigned ARB_W_DATA = 128;

   typedef enum logic [0:0] {
      OWN_DMA    = 1'b0,
      OWN_CUSTOM = 1'b1
   } owner_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      if (val == 16'hFFFF) begin
         res = val;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/arb_owner_fsm.sv
// ---------------------------------------------------------------------------
// arb_owner_fsm
// Ownership state machine for the RAM arbiter. The DMA owns the RAM after
// reset; ownership moves to the custom logic once the DMA has been idle for
// IDLE_CYC consecutive cycles, and returns to the DMA at the first edge on
// which the DMA is active again.
//
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   dma_active_i in   DMA is issuing a read or write this cycle
//   state_o      out  current owner (registered)
//   custom_en_o  out  custom logic owns the RAM (registered)
// ---------------------------------------------------------------------------
module arb_owner_fsm
   import arb_pkg::*;
#(
   parameter int unsigned IDLE_CYC = 2
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   dma_active_i,
   output owner_e state_o,
   output logic   custom_en_o
);

   // Counter only has to reach IDLE_CYC-1; keep at least one bit.
   localparam int unsigned W_CNT = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(IDLE_CYC - 1);

   owner_e             state_q, state_d;
   logic [W_CNT-1:0]   cnt_q, cnt_d;
   logic               custom_en_q, custom_en_d;

   // Next-state and idle-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         OWN_DMA: begin
            if (dma_active_i) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               // This edge closes the IDLE_CYC-th idle cycle.
               state_d = OWN_CUSTOM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + W_CNT'(1);
            end
         end
         OWN_CUSTOM: begin
            if (dma_active_i) begin
               state_d = OWN_DMA;
               cnt_d   = '0;
            end else begin
               state_d = OWN_CUSTOM;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = OWN_DMA;
            cnt_d   = '0;
         end
      endcase
      custom_en_d = (state_d == OWN_CUSTOM);
   end

   // State, idle counter and custom_en registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= OWN_DMA;
         cnt_q       <= '0;
         custom_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         custom_en_q <= custom_en_d;
      end
   end

   assign state_o     = state_q;
   assign custom_en_o = custom_en_q;

endmodule

// File: rtl/dma_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dma_ram_arbiter
// Shares one simple dual-port block RAM (one write port, one registered read
// port) between the PCIe DMA engine and the custom pulse logic. The DMA wins
// combinationally whenever it is active; otherwise the current owner drives
// the RAM. Read data is steered back to whichever master issued the read.
//
// Optional feature (macro ARB_DROP_CNT_EN): adds drop_cnt, a saturating count
// of cycles in which the custom logic owned the RAM but had a request
// dropped because the DMA took the RAM back.
//
// Ports:
//   clk_in, rst                        clock, synchronous active-high reset
//   ram_wr_addr/ram_wr_data/ram_wr_en  RAM write port
//   ram_rd_addr/ram_rd_en/ram_rd_data  RAM read port (data 1 cycle after en)
//   dma_*                              DMA requests and read return
//   custom_*                           custom-logic requests and read return
//   custom_en                          custom logic owns the RAM (registered)
//   drop_cnt                           dropped custom requests (optional)
// ---------------------------------------------------------------------------
module dma_ram_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned W_ADDR   = ARB_W_ADDR,
   parameter int unsigned W_DATA   = ARB_W_DATA,
   parameter int unsigned IDLE_CYC = 2
) (
   input  logic              clk_in,
   input  logic              rst,
   output logic [W_ADDR-1:0] ram_wr_addr,
   output logic [W_ADDR-1:0] ram_rd_addr,
   output logic [W_DATA-1:0] ram_wr_data,
   output logic              ram_wr_en,
   output logic              ram_rd_en,
   input  logic [W_DATA-1:0] ram_rd_data,
   input  logic [W_ADDR-1:0] dma_wr_addr,
   input  logic [W_ADDR-1:0] dma_rd_addr,
   input  logic [W_DATA-1:0] dma_wr_data,
   input  logic              dma_wr_en,
   input  logic              dma_rd_en,
   output logic [W_DATA-1:0] dma_rd_data,
   output logic              custom_en,
   input  logic [W_ADDR-1:0] custom_wr_addr,
   input  logic [W_ADDR-1:0] custom_rd_addr,
   input  logic [W_DATA-1:0] custom_wr_data,
   input  logic              custom_wr_en,
   input  logic              custom_rd_en,
   output logic [W_DATA-1:0] custom_rd_data
`ifdef ARB_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   logic   dma_active_s;
   logic   dma_sel_s;
   owner_e state_s;
   logic   sel_wr_en_s;
   logic   sel_rd_en_s;
   logic   rd_vld_q, rd_vld_d;
   owner_e rd_owner_q, rd_owner_d;

   assign dma_active_s = dma_wr_en | dma_rd_en;
   // An active DMA preempts in the same cycle, before the state has moved.
   assign dma_sel_s    = dma_active_s | (state_s == OWN_DMA);

   arb_owner_fsm #(
      .IDLE_CYC (IDLE_CYC)
   ) u_owner_fsm (
      .clk_i        (clk_in),
      .rst_i        (rst),
      .dma_active_i (dma_active_s),
      .state_o      (state_s),
      .custom_en_o  (custom_en)
   );

   // RAM port routing; enables are forced low while reset is asserted.
   always_comb begin
      if (dma_sel_s) begin
         ram_wr_addr = dma_wr_addr;
         ram_rd_addr = dma_rd_addr;
         ram_wr_data = dma_wr_data;
         sel_wr_en_s = dma_wr_en;
         sel_rd_en_s = dma_rd_en;
      end else begin
         ram_wr_addr = custom_wr_addr;
         ram_rd_addr = custom_rd_addr;
         ram_wr_data = custom_wr_data;
         sel_wr_en_s = custom_wr_en;
         sel_rd_en_s = custom_rd_en;
      end
      if (rst) begin
         ram_wr_en = 1'b0;
         ram_rd_en = 1'b0;
      end else begin
         ram_wr_en = sel_wr_en_s;
         ram_rd_en = sel_rd_en_s;
      end
   end

   // Tag the read issued this cycle with its owner.
   always_comb begin
      rd_vld_d = ram_rd_en;
      if (dma_sel_s) begin
         rd_owner_d = OWN_DMA;
      end else begin
         rd_owner_d = OWN_CUSTOM;
      end
   end

   // Read-owner tag register, cleared to "no read" by reset.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         rd_vld_q   <= 1'b0;
         rd_owner_q <= OWN_DMA;
      end else begin
         rd_vld_q   <= rd_vld_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Steer returning read data; the non-requesting master sees zero.
   always_comb begin
      dma_rd_data    = '0;
      custom_rd_data = '0;
      if (rd_vld_q) begin
         if (rd_owner_q == OWN_DMA) begin
            dma_rd_data = ram_rd_data;
         end else begin
            custom_rd_data = ram_rd_data;
         end
      end else begin
         dma_rd_data    = '0;
         custom_rd_data = '0;
      end
   end

`ifdef ARB_DROP_CNT_EN
   logic [15:0] drop_q, drop_d;

   // Count owned cycles in which a custom request lost to the DMA.
   always_comb begin
      if (custom_en && dma_active_s && (custom_wr_en || custom_rd_en)) begin
         drop_d = sat_inc16(drop_q);
      end else begin
         drop_d = drop_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         drop_q <= 16'd0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_dma_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_ram_arbiter
// Self-checking bench for dma_ram_arbiter. A behavioural RAM sits on the
// ram_* port. A reference model tracks ownership by counting idle cycles,
// mirrors the table contents in an array and predicts read returns.
// ---------------------------------------------------------------------------
module tb_dma_ram_arbiter;

   localparam int W_ADDR   = 12;
   localparam int W_DATA   = 128;
   localparam int IDLE_CYC = 2;
   localparam int DEPTH    = 1 << W_ADDR;

   logic              clk_in;
   logic              rst;
   logic [W_ADDR-1:0] ram_wr_addr, ram_rd_addr;
   logic [W_DATA-1:0] ram_wr_data;
   logic              ram_wr_en, ram_rd_en;
   logic [W_DATA-1:0] ram_rd_data;
   logic [W_ADDR-1:0] dma_wr_addr, dma_rd_addr;
   logic [W_DATA-1:0] dma_wr_data;
   logic              dma_wr_en, dma_rd_en;
   logic [W_DATA-1:0] dma_rd_data;
   logic              custom_en;
   logic [W_ADDR-1:0] custom_wr_addr, custom_rd_addr;
   logic [W_DATA-1:0] custom_wr_data;
   logic              custom_wr_en, custom_rd_en;
   logic [W_DATA-1:0] custom_rd_data;
`ifdef ARB_DROP_CNT_EN
   logic [15:0]       drop_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit                m_custom;
   int                m_idle;
   logic [W_DATA-1:0] m_mem [0:DEPTH-1];
   bit                m_pend_dma, m_pend_cus;
   logic [W_DATA-1:0] m_rd_val;
   int                m_drop;

   // Behavioural RAM
   logic [W_DATA-1:0] ram_mem [0:DEPTH-1];
   logic              ram_clear;

   logic [W_DATA-1:0] tbl [0:4];

   dma_ram_arbiter #(
      .W_ADDR   (W_ADDR),
      .W_DATA   (W_DATA),
      .IDLE_CYC (IDLE_CYC)
   ) dut (
      .clk_in         (clk_in),
      .rst            (rst),
      .ram_wr_addr    (ram_wr_addr),
      .ram_rd_addr    (ram_rd_addr),
      .ram_wr_data    (ram_wr_data),
      .ram_wr_en      (ram_wr_en),
      .ram_rd_en      (ram_rd_en),
      .ram_rd_data    (ram_rd_data),
      .dma_wr_addr    (dma_wr_addr),
      .dma_rd_addr    (dma_rd_addr),
      .dma_wr_data    (dma_wr_data),
      .dma_wr_en      (dma_wr_en),
      .dma_rd_en      (dma_rd_en),
      .dma_rd_data    (dma_rd_data),
      .custom_en      (custom_en),
      .custom_wr_addr (custom_wr_addr),
      .custom_rd_addr (custom_rd_addr),
      .custom_wr_data (custom_wr_data),
      .custom_wr_en   (custom_wr_en),
      .custom_rd_en   (custom_rd_en),
      .custom_rd_data (custom_rd_data)
`ifdef ARB_DROP_CNT_EN
      ,
      .drop_cnt       (drop_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Simple dual-port RAM, read-before-write on the same edge.
   always @(posedge clk_in) begin
      if (ram_clear) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
         ram_rd_data <= '0;
      end else begin
         if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
         if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
      end
   end

   // Advance the reference model by one clock using the current inputs,
   // then move to 1 time unit after the edge.
   task automatic tick();
      bit dact, dsel;
      dact = dma_wr_en || dma_rd_en;
      dsel = dact || !m_custom;
      if (rst) begin
         m_custom   = 1'b0;
         m_idle     = 0;
         m_pend_dma = 1'b0;
         m_pend_cus = 1'b0;
         m_drop     = 0;
      end else begin
         m_rd_val   = dsel ? m_mem[dma_rd_addr] : m_mem[custom_rd_addr];
         m_pend_dma = dsel && dma_rd_en;
         m_pend_cus = !dsel && custom_rd_en;
         if (dsel && dma_wr_en) m_mem[dma_wr_addr] = dma_wr_data;
         if (!dsel && custom_wr_en) m_mem[custom_wr_addr] = custom_wr_data;
         if (m_custom && dact && (custom_wr_en || custom_rd_en) && m_drop < 65535)
            m_drop++;
         if (!m_custom) begin
            if (dact) m_idle = 0;
            else if (m_idle + 1 >= IDLE_CYC) begin m_custom = 1'b1; m_idle = 0; end
            else m_idle++;
         end else if (dact) begin
            m_custom = 1'b0;
            m_idle   = 0;
         end
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      dma_wr_en = 1'b0; dma_rd_en = 1'b0;
      custom_wr_en = 1'b0; custom_rd_en = 1'b0;
      dma_wr_addr = '0; dma_rd_addr = '0; dma_wr_data = '0;
      custom_wr_addr = '0; custom_rd_addr = '0; custom_wr_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dma_wr_en = 1'b1; dma_rd_en = 1'b1;
      #1;
      checks++;
      if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_enables: wr_en=%b rd_en=%b required 0 0", ram_wr_en, ram_rd_en);
      end
      tick();
      ram_clear = 1'b0;
      rst = 1'b0;
      idle_inputs();
      checks++;
      if (custom_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_custom_en: got %b required 0", custom_en);
      end
      checks++;
      if (dma_rd_data !== '0 || custom_rd_data !== '0) begin
         errors++;
         $display("FAIL reset_rd_data: dma=%h custom=%h required 0", dma_rd_data, custom_rd_data);
      end
`ifdef ARB_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
      end
`endif
   endtask

   task automatic test_table_load();
      for (int i = 0; i < 5; i++) begin
         dma_wr_en = 1'b1;
         dma_wr_addr = W_ADDR'(i);
         dma_wr_data = tbl[i];
         #1;
         checks++;
         if (ram_wr_en !== 1'b1 || ram_wr_addr !== W_ADDR'(i) || ram_wr_data !== tbl[i]) begin
            errors++;
            $display("FAIL load_route[%0d]: en=%b addr=%h data=%h required 1 %h %h",
                     i, ram_wr_en, ram_wr_addr, ram_wr_data, i, tbl[i]);
         end
         tick();
         checks++;
         if (custom_en !== 1'b0) begin
            errors++;
            $display("FAIL load_custom_en[%0d]: got %b required 0", i, custom_en);
         end
      end
      dma_wr_en = 1'b0;
   endtask

   task automatic test_handover();
      // Custom writes before the handover edge must be blocked.
      custom_wr_en = 1'b1;
      custom_wr_addr = 12'd7;
      custom_wr_data = 128'hDEAD_BEEF;
      for (int e = 1; e <= IDLE_CYC; e++) begin
         #1;
         checks++;
         if (ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL handover_block[%0d]: ram_wr_en=%b required 0", e, ram_wr_en);
         end
         tick();
         checks++;
         if (custom_en !== (e == IDLE_CYC)) begin
            errors++;
            $display("FAIL handover_edge[%0d]: custom_en=%b required %b", e, custom_en, e == IDLE_CYC);
         end
      end
      custom_wr_en = 1'b0;
   endtask

   task automatic test_custom_read();
      custom_rd_en = 1'b1;
      custom_rd_addr = 12'd1;
      #1;
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 12'd1) begin
         errors++;
         $display("FAIL cread_route: en=%b addr=%h required 1 001", ram_rd_en, ram_rd_addr);
      end
      tick();
      custom_rd_en = 1'b0;
      checks++;
      if (custom_rd_data !== tbl[1] || dma_rd_data !== '0) begin
         errors++;
         $display("FAIL cread_data: custom=%h dma=%h required %h 0", custom_rd_data, dma_rd_data, tbl[1]);
      end
      // The write to address 7 issued before handover must have been dropped.
      custom_rd_en = 1'b1;
      custom_rd_addr = 12'd7;
      custom_wr_en = 1'b1;
      custom_wr_addr = 12'd8;
      custom_wr_data = 128'h1234_5678_9ABC_DEF0;
      tick();
      custom_wr_en = 1'b0;
      checks++;
      if (custom_rd_data !== '0) begin
         errors++;
         $display("FAIL cread_dropped_wr: got %h required 0", custom_rd_data);
      end
      custom_rd_addr = 12'd8;
      tick();
      custom_rd_en = 1'b0;
      checks++;
      if (custom_rd_data !== 128'h1234_5678_9ABC_DEF0) begin
         errors++;
         $display("FAIL cwrite_readback: got %h required 123456789abcdef0", custom_rd_data);
      end
      tick();
      checks++;
      if (custom_rd_data !== '0 || dma_rd_data !== '0 || custom_en !== 1'b1) begin
         errors++;
         $display("FAIL no_read_zero: custom=%h dma=%h custom_en=%b required 0 0 1",
                  custom_rd_data, dma_rd_data, custom_en);
      end
   endtask

   task automatic test_preemption();
      dma_rd_en = 1'b1; dma_rd_addr = 12'd2;
      custom_rd_en = 1'b1; custom_rd_addr = 12'd3;
      #1;
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 12'd2) begin
         errors++;
         $display("FAIL preempt_route: en=%b addr=%h required 1 002", ram_rd_en, ram_rd_addr);
      end
      tick();
      dma_rd_en = 1'b0; custom_rd_en = 1'b0;
      checks++;
      if (dma_rd_data !== tbl[2] || custom_rd_data !== '0) begin
         errors++;
         $display("FAIL preempt_data: dma=%h custom=%h required %h 0", dma_rd_data, custom_rd_data, tbl[2]);
      end
      checks++;
      if (custom_en !== 1'b0) begin
         errors++;
         $display("FAIL preempt_custom_en: got %b required 0", custom_en);
      end
`ifdef ARB_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd1) begin
         errors++;
         $display("FAIL preempt_drop_cnt: got %0d required 1", drop_cnt);
      end
`endif
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < IDLE_CYC; i++) tick();
      custom_wr_en = 1'b1; custom_wr_addr = 12'd9; custom_wr_data = 128'h55;
      #1;
      checks++;
      if (ram_wr_en !== 1'b1 || custom_en !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: ram_wr_en=%b custom_en=%b required 1 1", ram_wr_en, custom_en);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ram_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_block: ram_wr_en=%b required 0", ram_wr_en);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (custom_en !== 1'b0 || ram_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: custom_en=%b ram_wr_en=%b required 0 0", custom_en, ram_wr_en);
      end
`ifdef ARB_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midrst_drop_cnt: got %0d required 0", drop_cnt);
      end
`endif
      custom_wr_en = 1'b0;
   endtask

   task automatic test_random();
      bit dact, dsel;
      logic exp_we, exp_re;
      int r;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         dma_wr_en = (r == 0);
         dma_rd_en = (r == 1) || (r == 2 && n[0]);
         dma_wr_addr = W_ADDR'($urandom_range(0, 15));
         dma_rd_addr = W_ADDR'($urandom_range(0, 15));
         dma_wr_data = {$urandom, $urandom, $urandom, $urandom};
         custom_wr_en = $urandom_range(0, 1) == 1;
         custom_rd_en = $urandom_range(0, 1) == 1;
         custom_wr_addr = W_ADDR'($urandom_range(0, 15));
         custom_rd_addr = W_ADDR'($urandom_range(0, 15));
         custom_wr_data = {$urandom, $urandom, $urandom, $urandom};
         rst = ($urandom_range(0, 63) == 0);
         #1;
         dact = dma_wr_en || dma_rd_en;
         dsel = dact || !m_custom;
         exp_we = rst ? 1'b0 : (dsel ? dma_wr_en : custom_wr_en);
         exp_re = rst ? 1'b0 : (dsel ? dma_rd_en : custom_rd_en);
         checks++;
         if (ram_wr_en !== exp_we || ram_rd_en !== exp_re) begin
            errors++;
            $display("FAIL rnd_enables[%0d]: wr=%b rd=%b required %b %b", n, ram_wr_en, ram_rd_en, exp_we, exp_re);
         end
         if (!rst) begin
            checks++;
            if (ram_wr_addr !== (dsel ? dma_wr_addr : custom_wr_addr) ||
                ram_rd_addr !== (dsel ? dma_rd_addr : custom_rd_addr) ||
                ram_wr_data !== (dsel ? dma_wr_data : custom_wr_data)) begin
               errors++;
               $display("FAIL rnd_route[%0d]: wa=%h ra=%h wd=%h dma_sel=%b", n, ram_wr_addr, ram_rd_addr, ram_wr_data, dsel);
            end
         end
         tick();
         checks++;
         if (custom_en !== m_custom) begin
            errors++;
            $display("FAIL rnd_custom_en[%0d]: got %b required %b", n, custom_en, m_custom);
         end
         checks++;
         if (dma_rd_data !== (m_pend_dma ? m_rd_val : '0) ||
             custom_rd_data !== (m_pend_cus ? m_rd_val : '0)) begin
            errors++;
            $display("FAIL rnd_rd_data[%0d]: dma=%h custom=%h required %h %h", n, dma_rd_data, custom_rd_data,
                     m_pend_dma ? m_rd_val : '0, m_pend_cus ? m_rd_val : '0);
         end
`ifdef ARB_DROP_CNT_EN
         checks++;
         if (drop_cnt !== 16'(m_drop)) begin
            errors++;
            $display("FAIL rnd_drop_cnt[%0d]: got %0d required %0d", n, drop_cnt, m_drop);
         end
`endif
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      tbl[0] = 128'h10;
      tbl[1] = 128'h0000_0064_012c_03e8;
      tbl[2] = 128'h05dc_07d0_09c4_0bb8;
      tbl[3] = 128'h0dac_0fa0_1194_1388;
      tbl[4] = 128'h157c_1770_189c_194f;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_custom = 1'b0; m_idle = 0; m_pend_dma = 1'b0; m_pend_cus = 1'b0;
      m_rd_val = '0; m_drop = 0;
      ram_clear = 1'b1;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_table_load();
      test_handover();
      test_custom_read();
      test_preemption();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
